floor_request_scheduler: RTL and testbench

Upstream stage of the elevator controller: debounces the raw hall/car call buttons, latches them as pending floor requests, and picks the next floor to serve with a collective (SCAN) policy. It drives `requested_floor` into the elevator state machine and consumes that machine's `current_floor` to detect arrival. It also holds the car at each served floor for a door-dwell period before clearing the request.

---
 rtl/elevator_pkg.sv | 16 +
 rtl/button_debounce.sv | 49 ++++
 rtl/floor_request_scheduler.sv | 163 ++++++++++++++++
 tb/tb_floor_request_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Definitions shared by the elevator controller blocks: floor width,
// sweep direction encoding and the request scheduler state encoding.
package elevator_pkg;

  localparam int FLOOR_W = 4;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DWELL = 2'd2
  } sched_state_e;

endpackage

// File: rtl/button_debounce.sv
// One call button: 2-flop synchroniser, stability counter and a one-cycle
// pulse when the debounced level rises.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  // Synchronise, count consecutive mismatches and flip the level on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_rise  <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/floor_request_scheduler.sv
// Latches debounced call buttons as pending requests and chooses the next
// floor with a collective sweep, holding each served floor for a door dwell.
module floor_request_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS      = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DWELL_CYCLES    = 20000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] i_btn,
  input  logic [FLOOR_W-1:0]    i_current_floor,
  output logic [FLOOR_W-1:0]    o_requested_floor,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_dir_down,
  output logic                  o_door_open
);

  localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW_W-1:0]    DW_LAST = DW_W'(DWELL_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] NUM_F   = FLOOR_W'(NUM_FLOORS);

  sched_state_e          r_state, w_state_nx;
  logic [FLOOR_W-1:0]    r_target, w_target_nx;
  logic [FLOOR_W-1:0]    r_req, w_req_nx;
  logic                  r_dir_down, w_dir_nx;
  logic                  r_door, w_door_nx;
  logic [DW_W-1:0]       r_dwell_cnt, w_dwell_nx;
  logic [NUM_FLOORS-1:0] r_pending;

  logic [NUM_FLOORS-1:0] w_rise, w_set, w_clear, w_tgt_onehot;
  logic                  w_cur_valid, w_at_cur;
  logic                  w_up_found, w_dn_found, w_ahead_found, w_behind_found;
  logic [FLOOR_W-1:0]    w_up_floor, w_dn_floor, w_ahead_floor, w_behind_floor;
  logic                  w_ahead_closer;

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_btn  (i_btn[g]),
      .o_rise (w_rise[g])
    );
  end

  // Nearest pending floor above (lowest wins) and below (highest wins) the car
  always_comb begin
    w_up_found   = 1'b0;
    w_up_floor   = '0;
    w_dn_found   = 1'b0;
    w_dn_floor   = '0;
    w_at_cur     = 1'b0;
    w_tgt_onehot = '0;
    for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
      w_up_floor = (r_pending[f] && (FLOOR_W'(f) > i_current_floor)) ? FLOOR_W'(f) : w_up_floor;
      w_up_found = w_up_found | (r_pending[f] && (FLOOR_W'(f) > i_current_floor));
    end
    for (int f = 0; f < NUM_FLOORS; f++) begin
      w_dn_floor      = (r_pending[f] && (FLOOR_W'(f) < i_current_floor)) ? FLOOR_W'(f) : w_dn_floor;
      w_dn_found      = w_dn_found | (r_pending[f] && (FLOOR_W'(f) < i_current_floor));
      w_at_cur        = w_at_cur | (r_pending[f] && (FLOOR_W'(f) == i_current_floor));
      w_tgt_onehot[f] = (FLOOR_W'(f) == r_target);
    end
  end

  assign w_cur_valid    = (i_current_floor < NUM_F);
  assign w_ahead_found  = r_dir_down ? w_dn_found : w_up_found;
  assign w_ahead_floor  = r_dir_down ? w_dn_floor : w_up_floor;
  assign w_behind_found = r_dir_down ? w_up_found : w_dn_found;
  assign w_behind_floor = r_dir_down ? w_up_floor : w_dn_floor;
  assign w_ahead_closer = r_dir_down ? (w_ahead_floor > r_target) : (w_ahead_floor < r_target);

  // Next-state and next-output decode for the scheduler FSM
  always_comb begin
    w_state_nx  = r_state;
    w_target_nx = r_target;
    w_req_nx    = r_req;
    w_dir_nx    = r_dir_down;
    w_door_nx   = 1'b0;
    w_dwell_nx  = '0;
    w_clear     = '0;
    if (!w_cur_valid) begin
      w_state_nx = ST_IDLE;
      w_req_nx   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_pending == '0) begin
            w_req_nx = i_current_floor;
          end else if (w_at_cur) begin
            w_state_nx  = ST_DWELL;
            w_target_nx = i_current_floor;
            w_req_nx    = i_current_floor;
            w_door_nx   = 1'b1;
          end else if (w_ahead_found) begin
            w_state_nx  = ST_SERVE;
            w_target_nx = w_ahead_floor;
            w_req_nx    = w_ahead_floor;
          end else begin
            w_state_nx  = ST_SERVE;
            w_dir_nx    = ~r_dir_down;
            w_target_nx = w_behind_floor;
            w_req_nx    = w_behind_floor;
          end
        end
        ST_SERVE: begin
          if (i_current_floor == r_target) begin
            w_state_nx = ST_DWELL;
            w_door_nx  = 1'b1;
          end else if (w_ahead_found && w_ahead_closer) begin
            w_target_nx = w_ahead_floor;
            w_req_nx    = w_ahead_floor;
          end else begin
            w_req_nx = r_target;
          end
        end
        ST_DWELL: begin
          if (r_dwell_cnt == DW_LAST) begin
            w_state_nx = ST_IDLE;
            w_clear    = w_tgt_onehot;
          end else begin
            w_door_nx  = 1'b1;
            w_dwell_nx = r_dwell_cnt + DW_W'(1);
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // The dwell floor ignores new presses; a clear beats a same-cycle set
  assign w_set = w_rise & ~((r_state == ST_DWELL) ? w_tgt_onehot : '0);

  // Scheduler state, requests and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_target    <= '0;
      r_req       <= '0;
      r_dir_down  <= DIR_UP;
      r_door      <= 1'b0;
      r_dwell_cnt <= '0;
      r_pending   <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_target    <= w_target_nx;
      r_req       <= w_req_nx;
      r_dir_down  <= w_dir_nx;
      r_door      <= w_door_nx;
      r_dwell_cnt <= w_dwell_nx;
      r_pending   <= (r_pending | w_set) & ~w_clear;
    end
  end

  assign o_requested_floor = r_req;
  assign o_pending         = r_pending;
  assign o_dir_down        = r_dir_down;
  assign o_door_open       = r_door;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench for floor_request_scheduler with a simple car model that
// steps the reported floor toward the requested floor every 10 cycles.
module tb_floor_request_scheduler;

  localparam int NF = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NF-1:0] btn;
  logic [3:0]    cur = 4'd0;
  logic [3:0]    req;
  logic [NF-1:0] pending;
  logic          dir_down;
  logic          door_open;

  logic          car_force;
  logic [3:0]    force_val;
  int            car_cnt = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            k;
  int            door_cnt;
  logic          seen;
  logic [3:0]    cur_at_reset;

  always #5 clk = ~clk;

  floor_request_scheduler #(
    .NUM_FLOORS      (NF),
    .DEBOUNCE_CYCLES (4),
    .DWELL_CYCLES    (8)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_btn             (btn),
    .i_current_floor   (cur),
    .o_requested_floor (req),
    .o_pending         (pending),
    .o_dir_down        (dir_down),
    .o_door_open       (door_open)
  );

  // Car model: one floor every 10 cycles toward the request, or a forced floor
  always @(posedge clk) begin
    #2;
    if (car_force) begin
      cur     = force_val;
      car_cnt = 0;
    end else if (!rst_n || cur == req) begin
      car_cnt = 0;
    end else if (car_cnt == 9) begin
      cur     = (cur < req) ? cur + 4'd1 : cur - 4'd1;
      car_cnt = 0;
    end else begin
      car_cnt = car_cnt + 1;
    end
  end

  task automatic check_value(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cur(input logic [3:0] f, input int budget, input string tag);
    int i = 0;
    while (cur != f && i < budget) begin
      @(negedge clk);
      i++;
    end
    check_value(tag, int'(cur), int'(f));
  endtask

  task automatic wait_pending(input logic [NF-1:0] m, input int budget, input string tag);
    int i = 0;
    while (pending != m && i < budget) begin
      @(negedge clk);
      i++;
    end
    check_value(tag, int'(pending), int'(m));
  endtask

  task automatic wait_door(input logic lvl, input int budget, input string tag);
    int i = 0;
    while (door_open != lvl && i < budget) begin
      @(negedge clk);
      i++;
    end
    check_value(tag, int'(door_open), int'(lvl));
  endtask

  task automatic count_door(output int n);
    n = 0;
    while (door_open && n < 30) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic relocate(input logic [3:0] f);
    car_force = 1'b1;
    force_val = f;
    tick(2);
    car_force = 1'b0;
    tick(2);
  endtask

  initial begin
    rst_n     = 1'b0;
    btn       = '0;
    car_force = 1'b1;
    force_val = 4'd0;
    tick(3);
    check_value("rst_req", int'(req), 0);
    check_value("rst_pending", int'(pending), 0);
    check_value("rst_dir", int'(dir_down), 0);
    check_value("rst_door", int'(door_open), 0);
    rst_n     = 1'b1;
    car_force = 1'b0;
    tick(2);
    check_value("idle_req", int'(req), 0);

    // Bouncing button 3, then a clean hold
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      btn[3] = 1'b1;
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        if (pending != '0) seen = 1'b1;
      end
      btn[3] = 1'b0;
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        if (pending != '0) seen = 1'b1;
      end
    end
    btn[3] = 1'b1;
    k = 0;
    while (!pending[3] && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_value("bounce_no_set", int'(seen), 0);
    check_value("press_latency", k, 7);
    check_value("press_once", int'(pending), 8'h08);
    tick(1);
    check_value("t1_target", int'(req), 3);
    btn[3] = 1'b0;
    wait_door(1'b1, 60, "t1_door_rise");
    check_value("t1_floor", int'(cur), 3);
    count_door(door_cnt);
    check_value("t1_dwell_len", door_cnt, 8);
    check_value("t1_cleared", int'(pending), 0);
    relocate(4'd0);

    // Floors 5 and 2 together from floor 0
    btn = 8'h24;
    wait_pending(8'h24, 20, "t2_pending");
    btn = '0;
    tick(1);
    check_value("t2_first_target", int'(req), 2);
    wait_cur(4'd2, 40, "t2_arrive");
    check_value("t2_door_not_yet", int'(door_open), 0);
    tick(1);
    check_value("t2_door_open", int'(door_open), 1);
    count_door(door_cnt);
    check_value("t2_dwell_len", door_cnt, 8);
    check_value("t2_clear2", int'(pending), 8'h20);
    tick(1);
    check_value("t2_next_target", int'(req), 5);
    wait_door(1'b1, 50, "t2_door5");
    wait_door(1'b0, 20, "t2_door5_close");
    relocate(4'd0);

    // Stop on the way: heading to 6, floor 4 pressed at floor 2
    btn = 8'h40;
    wait_pending(8'h40, 20, "t3_pending6");
    btn = '0;
    tick(1);
    check_value("t3_target6", int'(req), 6);
    wait_cur(4'd2, 40, "t3_at2");
    btn[4] = 1'b1;
    wait_pending(8'h50, 12, "t3_pending4");
    btn[4] = 1'b0;
    tick(1);
    check_value("t3_retarget", int'(req), 4);
    check_value("t3_before4", int'(cur < 4'd4), 1);
    wait_door(1'b1, 40, "t3_door4");
    check_value("t3_floor4", int'(cur), 4);
    wait_door(1'b0, 20, "t3_door4_close");
    check_value("t3_clear4", int'(pending), 8'h40);
    tick(1);
    check_value("t3_resume6", int'(req), 6);
    check_value("t3_dir_up", int'(dir_down), 0);
    wait_door(1'b1, 40, "t3_door6");
    check_value("t3_floor6", int'(cur), 6);
    wait_door(1'b0, 20, "t3_door6_close");

    // At 6 going up with requests 1 and 7
    btn = 8'h82;
    wait_pending(8'h82, 20, "t4_pending");
    btn = '0;
    tick(1);
    check_value("t4_target7", int'(req), 7);
    check_value("t4_dir_up", int'(dir_down), 0);
    wait_door(1'b1, 30, "t4_door7");
    check_value("t4_floor7", int'(cur), 7);
    wait_door(1'b0, 20, "t4_door7_close");
    check_value("t4_clear7", int'(pending), 8'h02);
    tick(1);
    check_value("t4_target1", int'(req), 1);
    check_value("t4_dir_down", int'(dir_down), 1);
    wait_cur(4'd1, 80, "t4_arrive1");
    wait_door(1'b1, 5, "t4_door1");
    wait_door(1'b0, 20, "t4_door1_close");

    // Press the dwell floor during its own dwell
    btn[4] = 1'b1;
    wait_pending(8'h10, 12, "t5_pending4");
    btn[4] = 1'b0;
    tick(1);
    check_value("t5_target4", int'(req), 4);
    check_value("t5_dir_up", int'(dir_down), 0);
    wait_door(1'b1, 50, "t5_door4");
    check_value("t5_floor4", int'(cur), 4);
    btn[4] = 1'b1;
    count_door(door_cnt);
    check_value("t5_dwell_len", door_cnt, 8);
    check_value("t5_discarded", int'(pending), 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (door_open || pending != '0) seen = 1'b1;
    end
    check_value("t5_stays_idle", int'(seen), 0);
    check_value("t5_req_hold", int'(req), 4);
    btn[4] = 1'b0;
    tick(10);

    // Floor report out of range
    car_force = 1'b1;
    force_val = 4'd9;
    tick(2);
    check_value("oor_req", int'(req), 0);
    btn[2] = 1'b1;
    wait_pending(8'h04, 12, "oor_pending");
    btn[2] = 1'b0;
    tick(2);
    check_value("oor_req_hold", int'(req), 0);
    check_value("oor_door", int'(door_open), 0);
    check_value("oor_retained", int'(pending), 8'h04);

    // Asynchronous reset while serving with pending 8'h24
    force_val = 4'd0;
    btn[5]    = 1'b1;
    tick(2);
    car_force = 1'b0;
    wait_pending(8'h24, 12, "t6_pending");
    btn = '0;
    tick(2);
    check_value("t6_serving", int'(req), 2);
    check_value("t6_no_door", int'(door_open), 0);
    #1;
    rst_n = 1'b0;
    #1;
    check_value("t6_async_req", int'(req), 0);
    check_value("t6_async_pending", int'(pending), 0);
    check_value("t6_async_dir", int'(dir_down), 0);
    check_value("t6_async_door", int'(door_open), 0);
    cur_at_reset = cur;
    tick(2);
    rst_n = 1'b1;
    tick(30);
    check_value("t6_no_pending", int'(pending), 0);
    check_value("t6_req_is_cur", int'(req), int'(cur_at_reset));
    check_value("t6_no_motion", int'(cur), int'(cur_at_reset));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
